// File: rtl/sa_pkg.sv
// Shared types and width helpers for the systolic-array host controller.
package sa_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FEED,
        WAIT_RES,
        DRAIN,
        ACK
    } state_e;

    function automatic int unsigned cnt_w(input int unsigned max_k);
        return $clog2(max_k + 1);
    endfunction

    function automatic int unsigned col_w(input int unsigned rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

endpackage

// File: rtl/sa_res_bank.sv
// Per-column result latches: first valid per column is kept until cleared.
module sa_res_bank #(
    parameter int unsigned ROWS     = 8,
    parameter int unsigned OUTWIDTH = 32,
    parameter int unsigned COLW     = 3
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          en,
    input  logic                          clr,
    input  logic [0:ROWS-1]               wr_valid,
    input  logic [ROWS-1:0][OUTWIDTH-1:0] wr_data,
    input  logic [COLW-1:0]               rd_idx,
    output logic                          all_valid,
    output logic [OUTWIDTH-1:0]           rd_data
);

    logic [ROWS-1:0][OUTWIDTH-1:0] lat;
    logic [0:ROWS-1]               flag;
    logic [0:ROWS-1]               cap;

    assign cap = wr_valid & ~flag & {ROWS{en}};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            lat  <= '0;
            flag <= '0;
        end else if (clr) begin
            flag <= '0;
        end else begin
            flag <= flag | cap;
            for (int i = 0; i < ROWS; i++) begin
                if (cap[i]) lat[i] <= wr_data[i];
            end
        end
    end

    // Counts columns arriving this cycle so DRAIN can start right after the last one.
    assign all_valid = &(flag | cap);
    assign rd_data   = flag[rd_idx] ? lat[rd_idx] : wr_data[rd_idx];

endmodule

// File: rtl/sa_host_ctrl.sv
// Host-side controller for the systolic-array core: feeds A/W beats, collects
// per-column results, streams them out, then acknowledges the core.
module sa_host_ctrl
    import sa_pkg::*;
#(
    parameter int unsigned ROWS     = 8,
    parameter int unsigned INWIDTH  = 8,
    parameter int unsigned OUTWIDTH = 32,
    parameter int unsigned MAX_K    = 256,
    parameter int unsigned TIMEOUT  = 1024
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [ROWS-1:0][INWIDTH-1:0]  s_a,
    input  logic [ROWS-1:0][INWIDTH-1:0]  s_w,
    input  logic                          s_last,
    output logic [ROWS-1:0][INWIDTH-1:0]  ainport,
    output logic [ROWS-1:0][INWIDTH-1:0]  winport,
    output logic                          inpvalid,
    input  logic [ROWS-1:0][OUTWIDTH-1:0] routport,
    input  logic [0:ROWS-1]               rvalidport,
    output logic                          outread,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [OUTWIDTH-1:0]           m_data,
    output logic [col_w(ROWS)-1:0]        m_col,
    output logic                          m_last,
    output logic                          busy,
    output logic [cnt_w(MAX_K)-1:0]       beat_cnt,
    output logic                          err_timeout
);

    localparam int unsigned CNTW = cnt_w(MAX_K);
    localparam int unsigned COLW = col_w(ROWS);
    localparam int unsigned TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e                state;
    logic [TW-1:0]         tcnt;
    logic                  hs;
    logic                  feed_done;
    logic                  all_valid;
    logic [OUTWIDTH-1:0]   rd_data;
    logic [COLW-1:0]       rd_idx;

    assign hs        = s_valid & s_ready;
    assign feed_done = s_last | (beat_cnt == CNTW'(MAX_K - 1));
    // Look one column ahead in DRAIN so m_data is ready when m_col advances.
    assign rd_idx    = (state == DRAIN) ? COLW'(m_col + 1'b1) : '0;

    sa_res_bank #(
        .ROWS     (ROWS),
        .OUTWIDTH (OUTWIDTH),
        .COLW     (COLW)
    ) u_bank (
        .clk       (clk),
        .rstn      (rstn),
        .en        ((state == FEED) || (state == WAIT_RES)),
        .clr       (state == ACK),
        .wr_valid  (rvalidport),
        .wr_data   (routport),
        .rd_idx    (rd_idx),
        .all_valid (all_valid),
        .rd_data   (rd_data)
    );

    // s_ready resets high because IDLE accepts beats.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= IDLE;
            s_ready     <= 1'b1;
            ainport     <= '0;
            winport     <= '0;
            inpvalid    <= 1'b0;
            beat_cnt    <= '0;
            tcnt        <= '0;
            err_timeout <= 1'b0;
            m_valid     <= 1'b0;
            m_data      <= '0;
            m_col       <= '0;
            m_last      <= 1'b0;
            outread     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            inpvalid <= hs;
            outread  <= 1'b0;
            if (hs) begin
                ainport <= s_a;
                winport <= s_w;
                if (beat_cnt != CNTW'(MAX_K)) beat_cnt <= beat_cnt + 1'b1;
            end
            case (state)
                // A job whose first beat is already last skips straight to WAIT_RES.
                IDLE, FEED: begin
                    if (hs) begin
                        busy <= 1'b1;
                        if (feed_done) begin
                            state   <= WAIT_RES;
                            s_ready <= 1'b0;
                        end else begin
                            state <= FEED;
                        end
                    end
                end
                WAIT_RES: begin
                    if (all_valid && !err_timeout) begin
                        state   <= DRAIN;
                        m_valid <= 1'b1;
                        m_col   <= '0;
                        m_data  <= rd_data;
                        m_last  <= (ROWS == 1);
                    end else if ((TIMEOUT != 0) && !err_timeout) begin
                        if (tcnt == TW'(TIMEOUT - 1)) err_timeout <= 1'b1;
                        else tcnt <= tcnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (m_ready) begin
                        if (m_last) begin
                            state    <= ACK;
                            m_valid  <= 1'b0;
                            m_last   <= 1'b0;
                            m_col    <= '0;
                            m_data   <= '0;
                            outread  <= 1'b1;
                            beat_cnt <= '0;
                        end else begin
                            m_col  <= COLW'(m_col + 1'b1);
                            m_data <= rd_data;
                            m_last <= (m_col == COLW'(ROWS - 2));
                        end
                    end
                end
                ACK: begin
                    state   <= IDLE;
                    s_ready <= 1'b1;
                    busy    <= 1'b0;
                    tcnt    <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sa_host_ctrl.sv
// Directed bench for sa_host_ctrl: feed, result capture, drain stalls, forced last, timeout, reset.
module tb_sa_host_ctrl;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic                 s_valid, s_ready, s_last;
    logic [7:0][7:0]      s_a, s_w, ainport, winport;
    logic                 inpvalid;
    logic [7:0][31:0]     routport;
    logic [0:7]           rvalidport;
    logic                 outread, m_valid, m_ready, m_last, busy, err_timeout;
    logic [31:0]          m_data;
    logic [2:0]           m_col;
    logic [2:0]           beat_cnt;

    int n_vec = 0;
    int n_bad = 0;
    int n_inp = 0;
    int n_outread = 0;
    logic [7:0][7:0]  exp_a, exp_w;
    logic [7:0][31:0] exp_r;

    sa_host_ctrl #(
        .ROWS(8), .INWIDTH(8), .OUTWIDTH(32), .MAX_K(4), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rstn(rstn),
        .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_w(s_w), .s_last(s_last),
        .ainport(ainport), .winport(winport), .inpvalid(inpvalid),
        .routport(routport), .rvalidport(rvalidport), .outread(outread),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_col(m_col), .m_last(m_last),
        .busy(busy), .beat_cnt(beat_cnt), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (inpvalid) n_inp++;
        if (outread)  n_outread++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer nbeats beats; the first n_acc are expected to be accepted.
    task automatic feed(input string tag, input int nbeats, input int n_acc, input int last_at,
                        input int seed);
        for (int b = 0; b < nbeats; b++) begin
            logic [7:0][7:0] a, w;
            for (int j = 0; j < 8; j++) begin
                a[j] = 8'(seed + 16 * b + j);
                w[j] = 8'(255 - seed - 16 * b - j);
            end
            s_valid = 1'b1;
            s_a     = a;
            s_w     = w;
            s_last  = (b == last_at - 1);
            chk({tag, "_rdy"}, s_ready, b < n_acc);
            step();
            if (b < n_acc) begin
                exp_a = a;
                exp_w = w;
            end
            chk({tag, "_inpv"}, inpvalid, b < n_acc);
            chk({tag, "_ain"}, ainport, exp_a);
            chk({tag, "_win"}, winport, exp_w);
            chk({tag, "_cnt"}, beat_cnt, (b < n_acc) ? b + 1 : n_acc);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Core presents every column in one cycle.
    task automatic all_cols(input string tag, input logic [31:0] base);
        for (int i = 0; i < 8; i++) begin
            routport[i] = base + 32'(i);
            exp_r[i]    = base + 32'(i);
        end
        rvalidport = '1;
        step();
        rvalidport = '0;
        chk({tag, "_inpv0"}, inpvalid, 1'b0);
    endtask

    task automatic drain(input string tag, input logic [15:0] pat);
        int col = 0;
        int cyc = 0;
        while (col < 8 && cyc < 16) begin
            chk({tag, "_mv"}, m_valid, 1'b1);
            chk({tag, "_col"}, m_col, col);
            chk({tag, "_dat"}, m_data, exp_r[col]);
            chk({tag, "_last"}, m_last, col == 7);
            m_ready = pat[cyc];
            step();
            if (pat[cyc]) col++;
            cyc++;
        end
        m_ready = 1'b0;
        chk({tag, "_ncol"}, col, 8);
        chk({tag, "_ack"}, outread, 1'b1);
        chk({tag, "_mv0"}, m_valid, 1'b0);
    endtask

    task automatic back_to_idle(input string tag);
        step();
        chk({tag, "_or0"}, outread, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_srdy"}, s_ready, 1'b1);
        chk({tag, "_cnt0"}, beat_cnt, 0);
    endtask

    initial begin
        rstn = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_a = '0; s_w = '0;
        routport = '0; rvalidport = '0; m_ready = 1'b0;
        exp_a = '0; exp_w = '0; exp_r = '0;
        step();
        step();
        chk("rst_busy", busy, 1'b0);
        chk("rst_srdy", s_ready, 1'b1);
        chk("rst_mv", m_valid, 1'b0);
        chk("rst_or", outread, 1'b0);
        chk("rst_inpv", inpvalid, 1'b0);
        chk("rst_cnt", beat_cnt, 0);
        chk("rst_err", err_timeout, 1'b0);
        chk("rst_ain", ainport, 64'h0);
        rstn = 1'b1;

        // 1: four beats, all columns together, clean drain
        feed("t1", 4, 4, 4, 8'h10);
        chk("t1_busy", busy, 1'b1);
        chk("t1_srdy0", s_ready, 1'b0);
        all_cols("t1", 32'd100);
        chk("t1_npulse", n_inp, 4);
        drain("t1", 16'hFFFF);
        back_to_idle("t1");
        chk("t1_nor", n_outread, 1);

        // 2: staggered columns, col 0 during FEED, later value on col 0 ignored
        routport = '0;
        rvalidport = '0;
        routport[0] = 32'h200;
        rvalidport[0] = 1'b1;
        exp_r[0] = 32'h200;
        feed("t2", 3, 3, 3, 8'h40);
        routport[0] = 32'hDEAD;
        for (int c = 1; c < 8; c++) begin
            routport[c] = 32'h200 + 32'(c);
            exp_r[c] = 32'h200 + 32'(c);
            rvalidport[c] = 1'b1;
            chk("t2_early", m_valid, 1'b0);
            step();
        end
        rvalidport = '0;
        drain("t2", 16'hFFFF);
        back_to_idle("t2");

        // 3: m_ready 1,0,0,1 then high
        feed("t3", 2, 2, 2, 8'h60);
        all_cols("t3", 32'h300);
        drain("t3", 16'hFFF9);
        back_to_idle("t3");

        // 4: six beats offered without s_last, MAX_K=4 forces last
        feed("t4", 6, 4, 0, 8'h80);
        chk("t4_cnt", beat_cnt, 4);
        chk("t4_srdy", s_ready, 1'b0);
        all_cols("t4", 32'h400);
        drain("t4", 16'hFFFF);
        back_to_idle("t4");
        chk("t4_nor", n_outread, 4);

        // 6: reset for one cycle in the middle of DRAIN
        feed("t6", 2, 2, 2, 8'hA0);
        all_cols("t6", 32'h600);
        m_ready = 1'b1;
        step(); step(); step();
        m_ready = 1'b0;
        chk("t6_midcol", m_col, 3);
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        chk("t6_busy", busy, 1'b0);
        chk("t6_mv", m_valid, 1'b0);
        chk("t6_col", m_col, 0);
        chk("t6_dat", m_data, 32'h0);
        chk("t6_or", outread, 1'b0);
        chk("t6_srdy", s_ready, 1'b1);
        chk("t6_cnt", beat_cnt, 0);
        chk("t6_ain", ainport, 64'h0);
        exp_a = '0;
        exp_w = '0;
        feed("t6b", 4, 4, 4, 8'hC0);
        all_cols("t6b", 32'h700);
        drain("t6b", 16'hFFFF);
        back_to_idle("t6b");
        chk("t6_nor", n_outread, 5);

        // 5: column 3 withheld, timeout after 16 WAIT_RES cycles
        feed("t5", 2, 2, 2, 8'hE0);
        for (int i = 0; i < 8; i++) routport[i] = 32'h500 + 32'(i);
        rvalidport = '1;
        rvalidport[3] = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            chk("t5_err0", err_timeout, 1'b0);
            step();
        end
        chk("t5_err1", err_timeout, 1'b1);
        chk("t5_mv", m_valid, 1'b0);
        rvalidport[3] = 1'b1;
        step(); step(); step();
        chk("t5_stuck_mv", m_valid, 1'b0);
        chk("t5_stuck_busy", busy, 1'b1);
        chk("t5_sticky", err_timeout, 1'b1);
        chk("t5_nor", n_outread, 5);
        rvalidport = '0;
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        chk("t5_err_rst", err_timeout, 1'b0);
        chk("t5_srdy_rst", s_ready, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
